// File: rtl/pwl_pkg.sv
// Shared constants and FSM state type for the piecewise-linear activation units.
package pwl_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    READY,
    ERROR
  } state_t;

  localparam int DEF_XDW     = 16;
  localparam int DEF_SEG_NUM = 8;

endpackage

// File: rtl/bp_table_reg.sv
// Breakpoint register array: one write port, registered dual read of bp[idx]/bp[idx+1]
// with an out-of-range guard that forces zeros and drops valid.
module bp_table_reg import pwl_pkg::*; #(
  parameter int DW      = DEF_XDW,
  parameter int SEG_NUM = DEF_SEG_NUM,
  parameter int IDX_W   = $clog2(SEG_NUM + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [DW-1:0]    wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [DW-1:0]    a_out,
  output logic [DW-1:0]    b_out,
  output logic             valid
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(SEG_NUM);

  logic [DW-1:0] mem [SEG_NUM+1];
  logic          in_range;

  // idx+1 stays inside the array whenever idx < SEG_NUM, so the guard covers both reads.
  assign in_range = rd_en && (rd_idx < LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i <= unsigned'(SEG_NUM); i++) mem[i] <= '0;
      a_out <= '0;
      b_out <= '0;
      valid <= 1'b0;
    end else begin
      if (wr_en) mem[wr_idx] <= wr_data;
      a_out <= in_range ? mem[rd_idx] : '0;
      b_out <= in_range ? mem[rd_idx + IDX_W'(1)] : '0;
      valid <= in_range;
    end
  end

endmodule

// File: rtl/pwl_breakpoint_loader.sv
// Streams in SEG_NUM+1 strictly increasing breakpoints, rejects non-increasing tables,
// and serves registered (a, b) segment bounds once a table is loaded.
module pwl_breakpoint_loader import pwl_pkg::*; #(
  parameter int xDW     = DEF_XDW,
  parameter int SEG_NUM = DEF_SEG_NUM,
  parameter int IDX_W   = $clog2(SEG_NUM + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             bp_valid,
  input  logic [xDW-1:0]   bp_data,
  output logic             bp_ready,
  output logic             load_done,
  output logic             load_err,
  input  logic [IDX_W-1:0] seg_idx,
  output logic [xDW-1:0]   a_out,
  output logic [xDW-1:0]   b_out,
  output logic             bounds_valid
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(SEG_NUM);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic [xDW-1:0]   last_bp;
  logic             accept, mono_ok, wr_en, done_nxt, rd_en;

  assign bp_ready = (state == LOAD) && !load_start;
  assign load_err = (state == ERROR);
  assign accept   = bp_valid && bp_ready;
  // The first beat of a load has no predecessor to compare against.
  assign mono_ok  = (cnt == '0) || (bp_data > last_bp);
  assign wr_en    = accept && mono_ok;
  assign rd_en    = (state == READY) && !load_start;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    if (load_start) begin
      state_nxt = LOAD;
      cnt_nxt   = '0;
    end else if (state == LOAD && accept) begin
      if (!mono_ok) begin
        state_nxt = ERROR;
      end else if (cnt == LAST) begin
        state_nxt = READY;
        cnt_nxt   = '0;
        done_nxt  = 1'b1;
      end else begin
        cnt_nxt = cnt + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      cnt       <= '0;
      last_bp   <= '0;
      load_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      load_done <= done_nxt;
      if (wr_en) last_bp <= bp_data;
    end
  end

  bp_table_reg #(
    .DW      (xDW),
    .SEG_NUM (SEG_NUM),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (cnt),
    .wr_data (bp_data),
    .rd_en   (rd_en),
    .rd_idx  (seg_idx),
    .a_out   (a_out),
    .b_out   (b_out),
    .valid   (bounds_valid)
  );

endmodule

// File: tb/tb_pwl_breakpoint_loader.sv
// Randomized self-checking bench for pwl_breakpoint_loader against an array-based table model.
module tb_pwl_breakpoint_loader;

  localparam int W   = 16;
  localparam int SEG = 8;
  localparam int IW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          bp_valid = 1'b0;
  logic [W-1:0]  bp_data = '0;
  logic [IW-1:0] seg_idx = '0;
  logic          bp_ready, load_done, load_err, bounds_valid;
  logic [W-1:0]  a_out, b_out;

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] stim [$];
  logic [W-1:0] ref_tab [SEG+1];

  always #5 clk = ~clk;

  pwl_breakpoint_loader #(
    .xDW     (W),
    .SEG_NUM (SEG),
    .IDX_W   (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .bp_valid     (bp_valid),
    .bp_data      (bp_data),
    .bp_ready     (bp_ready),
    .load_done    (load_done),
    .load_err     (load_err),
    .seg_idx      (seg_idx),
    .a_out        (a_out),
    .b_out        (b_out),
    .bounds_valid (bounds_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_increasing();
    int v;
    stim.delete();
    v = $urandom_range(0, 500);
    for (int i = 0; i <= SEG; i++) begin
      stim.push_back(W'(v));
      v = v + $urandom_range(1, 7000);
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    bp_valid   = 1'b0;
    step();
    load_start = 1'b0;
  endtask

  // Streams stim[] with random gaps; model accepts a beat whenever bp_valid is offered in LOAD
  // and flags the first value that is not strictly above the previous accepted one.
  task automatic feed(input int gap_pct, input int max_beats, output int result, output int cycles);
    int i;
    bit offered;
    logic [W-1:0] prev;
    i = 0;
    cycles = 0;
    result = 2;
    prev = '0;
    while (i < stim.size() && i < max_beats && cycles < 200) begin
      offered  = ($urandom_range(0, 99) >= gap_pct);
      bp_valid = offered;
      bp_data  = offered ? stim[i] : W'($urandom);
      seg_idx  = IW'($urandom);
      #1;
      n_chk++;
      if (bp_ready !== 1'b1 || load_done !== 1'b0 || bounds_valid !== 1'b0 || load_err !== 1'b0) begin
        n_fail++;
        $display("FAIL load_cycle beat=%0d got ready=%b done=%b bv=%b err=%b want ready=1 done=0 bv=0 err=0",
                 i, bp_ready, load_done, bounds_valid, load_err);
      end
      step();
      cycles++;
      if (offered) begin
        if (i > 0 && stim[i] <= prev) begin
          result = 1;
          break;
        end
        ref_tab[i] = stim[i];
        prev = stim[i];
        i++;
      end
    end
    bp_valid = 1'b0;
    if (result != 1) begin
      if (i == stim.size()) result = 0;
      else if (i == max_beats) result = 3;
    end
  endtask

  // Entered on the first cycle in READY: done pulse, then a full index sweep.
  task automatic sweep_ready();
    n_chk++;
    if (load_done !== 1'b1 || bp_ready !== 1'b0 || bounds_valid !== 1'b0 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL done_cycle got done=%b ready=%b bv=%b err=%b want done=1 ready=0 bv=0 err=0",
               load_done, bp_ready, bounds_valid, load_err);
    end
    for (int k = 0; k < (1 << IW); k++) begin
      logic [W-1:0] ea, eb;
      logic ev;
      seg_idx = IW'(k);
      step();
      ev = (k < SEG);
      ea = ev ? ref_tab[k] : '0;
      eb = ev ? ref_tab[k+1] : '0;
      n_chk++;
      if (a_out !== ea || b_out !== eb || bounds_valid !== ev || load_done !== 1'b0) begin
        n_fail++;
        $display("FAIL lookup idx=%0d got a=%0d b=%0d bv=%b done=%b want a=%0d b=%0d bv=%b done=0",
                 k, a_out, b_out, bounds_valid, load_done, ea, eb, ev);
      end
    end
  endtask

  task automatic sweep_error();
    n_chk++;
    if (load_err !== 1'b1 || bp_ready !== 1'b0 || load_done !== 1'b0) begin
      n_fail++;
      $display("FAIL error_entry got err=%b ready=%b done=%b want err=1 ready=0 done=0",
               load_err, bp_ready, load_done);
    end
    bp_valid = 1'b1;
    for (int k = 0; k < (1 << IW); k++) begin
      seg_idx = IW'(k);
      bp_data = W'($urandom);
      step();
      n_chk++;
      if (bounds_valid !== 1'b0 || a_out !== '0 || b_out !== '0 || load_err !== 1'b1 || bp_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL error_lookup idx=%0d got bv=%b a=%0d b=%0d err=%b ready=%b want bv=0 a=0 b=0 err=1 ready=0",
                 k, bounds_valid, a_out, b_out, load_err, bp_ready);
      end
    end
    bp_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if ({bp_ready, load_done, load_err, bounds_valid} !== 4'b0 || a_out !== '0 || b_out !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got ready=%b done=%b err=%b bv=%b a=%0d b=%0d want all 0",
               bp_ready, load_done, load_err, bounds_valid, a_out, b_out);
    end
    step();
    step();
    rst = 1'b0;
    bp_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      seg_idx = IW'(k);
      step();
      n_chk++;
      if (bp_ready !== 1'b0 || bounds_valid !== 1'b0 || load_err !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_state got ready=%b bv=%b err=%b want 0 0 0", bp_ready, bounds_valid, load_err);
      end
    end
    bp_valid = 1'b0;
  endtask

  task automatic test_normal_load();
    int res, cyc;
    stim.delete();
    for (int i = 0; i <= SEG; i++) stim.push_back(W'(i * 100));
    start_load();
    feed(0, 99, res, cyc);
    n_chk++;
    if (res != 0 || cyc != SEG + 1) begin
      n_fail++;
      $display("FAIL normal_load got result=%0d cycles=%0d want result=0 cycles=%0d", res, cyc, SEG + 1);
    end
    sweep_ready();
    seg_idx = 3;
    step();
    n_chk++;
    if (a_out !== 16'd300 || b_out !== 16'd400 || bounds_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL seg3 got a=%0d b=%0d bv=%b want 300 400 1", a_out, b_out, bounds_valid);
    end
  endtask

  task automatic test_backpressure();
    int res, cyc;
    for (int r = 0; r < 3; r++) begin
      gen_increasing();
      start_load();
      feed(50, 99, res, cyc);
      n_chk++;
      if (res != 0) begin
        n_fail++;
        $display("FAIL gapped_load round=%0d got result=%0d want 0", r, res);
      end
      if (res == 0) sweep_ready();
    end
  endtask

  task automatic test_monotonic_error();
    int res, cyc, p, d;
    stim.delete();
    stim.push_back(16'd0);
    stim.push_back(16'd100);
    stim.push_back(16'd100);
    start_load();
    feed(0, 99, res, cyc);
    n_chk++;
    if (res != 1 || cyc != 3) begin
      n_fail++;
      $display("FAIL dup_error got result=%0d cycles=%0d want result=1 cycles=3", res, cyc);
    end
    sweep_error();
    gen_increasing();
    p = $urandom_range(1, SEG);
    d = $urandom_range(0, (stim[p-1] < 50) ? int'(stim[p-1]) : 50);
    stim[p] = stim[p-1] - W'(d);
    start_load();
    n_chk++;
    if (load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear got err=%b want 0", load_err);
    end
    feed(40, 99, res, cyc);
    n_chk++;
    if (res != 1) begin
      n_fail++;
      $display("FAIL random_error pos=%0d got result=%0d want 1", p, res);
    end
    sweep_error();
    gen_increasing();
    start_load();
    feed(20, 99, res, cyc);
    n_chk++;
    if (res != 0) begin
      n_fail++;
      $display("FAIL recover_load got result=%0d want 0", res);
    end
    if (res == 0) sweep_ready();
  endtask

  task automatic test_restart_collision();
    int res, cyc;
    gen_increasing();
    start_load();
    feed(30, 5, res, cyc);
    load_start = 1'b1;
    bp_valid   = 1'b1;
    bp_data    = stim[5];
    #1;
    n_chk++;
    if (bp_ready !== 1'b0 || res != 3) begin
      n_fail++;
      $display("FAIL collision_ready got ready=%b result=%0d want ready=0 result=3", bp_ready, res);
    end
    step();
    load_start = 1'b0;
    bp_valid   = 1'b0;
    gen_increasing();
    feed(0, 99, res, cyc);
    n_chk++;
    if (res != 0 || cyc != SEG + 1) begin
      n_fail++;
      $display("FAIL restart_load got result=%0d cycles=%0d want result=0 cycles=%0d", res, cyc, SEG + 1);
    end
    if (res == 0) sweep_ready();
  endtask

  task automatic test_async_reset();
    int res, cyc;
    gen_increasing();
    start_load();
    feed(0, 5, res, cyc);
    #3;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({bp_ready, load_done, load_err, bounds_valid} !== 4'b0 || a_out !== '0 || b_out !== '0) begin
      n_fail++;
      $display("FAIL async_reset got ready=%b done=%b err=%b bv=%b a=%0d b=%0d want all 0",
               bp_ready, load_done, load_err, bounds_valid, a_out, b_out);
    end
    for (int i = 0; i <= SEG; i++) ref_tab[i] = '0;
    #1;
    rst = 1'b0;
    bp_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      seg_idx = IW'(k);
      step();
      n_chk++;
      if (bp_ready !== 1'b0 || bounds_valid !== 1'b0 || load_done !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset got ready=%b bv=%b done=%b want 0 0 0", bp_ready, bounds_valid, load_done);
      end
    end
    bp_valid = 1'b0;
    gen_increasing();
    start_load();
    feed(25, 99, res, cyc);
    n_chk++;
    if (res != 0) begin
      n_fail++;
      $display("FAIL reload_after_reset got result=%0d want 0", res);
    end
    if (res == 0) sweep_ready();
  endtask

  initial begin
    for (int i = 0; i <= SEG; i++) ref_tab[i] = '0;
    test_reset();
    test_normal_load();
    test_backpressure();
    test_monotonic_error();
    test_restart_collision();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
